vliw_writeback_gen: RTL

Parametrised writeback stage for the VLIW core, replacing the fixed 3-lane/64-bit writeback. It registers the per-lane results coming from execute and drives them to the register file and the forwarding network. It also resolves same-bundle write-after-write conflicts. Read results go into a bounded queue with a valid/ready interface, and the stage back-pressures execute when that queue is full.

---
 rtl/vliw_pkg.sv | 34 +++
 rtl/vliw_writeback_gen_wb_read_fifo.sv | 76 +++++++
 rtl/vliw_writeback_gen.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/vliw_pkg.sv
// Shared VLIW definitions: default lane geometry, register names and lane slicing helpers.
// Imported by decode, execute and writeback so that lane layout stays consistent.
package vliw_pkg;

    localparam int NLANES_DEF = 3;
    localparam int DATA_W_DEF = 64;
    localparam int REG_AW_DEF = 4;

    // Architectural register names; REG0 is hardwired zero and writes to it are dropped by the RF.
    localparam int REG0    = 0;
    localparam int REG_RA  = 1;
    localparam int REG_SP  = 2;
    localparam int REG_GP  = 3;
    localparam int REG_TMP = 4;

    // What the writeback stage does with the bundle offered this cycle.
    typedef enum logic [1:0] {
        WB_IDLE   = 2'd0,
        WB_ACCEPT = 2'd1,
        WB_STALL  = 2'd2,
        WB_FLUSH  = 2'd3
    } wb_event_e;

    // Low bit index of lane `lane` in a flat vector of `width`-bit lanes.
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

    // Width of a flat vector holding `nlanes` lanes of `width` bits.
    function automatic int lanes_w(input int nlanes, input int width);
        return nlanes * width;
    endfunction

endpackage

// File: rtl/vliw_writeback_gen_wb_read_fifo.sv
// Bounded FIFO for read results leaving writeback; head is shown combinationally and zeroed when empty.
// Pointers wrap naturally because DEPTH is a power of two.
module wb_read_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     rd_valid,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // Simultaneous push and pop leave occupancy unchanged.
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever count is zero.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign rd_valid = ~empty;
    assign rd_data  = empty ? '0 : mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/vliw_writeback_gen.sv
// Parametrised VLIW writeback: registers per-lane results, resolves same-bundle WAW,
// and queues read results behind a valid/ready interface with back-pressure to execute.
module vliw_writeback_gen
    import vliw_pkg::*;
#(
    parameter int NLANES    = NLANES_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int REG_AW    = REG_AW_DEF,
    parameter int RDQ_DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         e2w_valid,
    input  logic [NLANES*REG_AW-1:0]     e2w_dest,
    input  logic [NLANES*DATA_W-1:0]     e2w_data,
    input  logic [NLANES-1:0]            e2w_wr,
    input  logic [NLANES-1:0]            e2w_read,
    output logic                         w2e_stall,
    output logic [NLANES-1:0]            w2r_wr,
    output logic [NLANES*REG_AW-1:0]     w2re_dest,
    output logic [NLANES*DATA_W-1:0]     w2re_data,
    output logic                         rd_valid,
    output logic [NLANES*DATA_W-1:0]     rd_data,
    output logic [NLANES-1:0]            rd_mask,
    input  logic                         rd_ready,
    output logic [$clog2(RDQ_DEPTH):0]   rdq_count
);

    localparam int DW_ALL  = lanes_w(NLANES, DATA_W);
    localparam int AW_ALL  = lanes_w(NLANES, REG_AW);
    localparam int RQ_W    = lanes_w(NLANES, DATA_W + 1);

    localparam logic [REG_AW-1:0] REG0_A = REG_AW'(REG0);

    logic [NLANES-1:0]  kill;
    logic               need_rdq;
    logic               rdq_full;
    logic               accept;
    wb_event_e          wb_evt;

    logic [NLANES-1:0]  w2r_wr_q, w2r_wr_d;
    logic [AW_ALL-1:0]  w2re_dest_q, w2re_dest_d;
    logic [DW_ALL-1:0]  w2re_data_q, w2re_data_d;

    logic [DW_ALL-1:0]  rdq_push_data;
    logic [RQ_W-1:0]    rdq_push_entry;
    logic [RQ_W-1:0]    rdq_head;

    assign need_rdq = |e2w_read;

    // Stall looks only at the registered full flag, so a pop this cycle cannot release it.
    assign w2e_stall = e2w_valid & need_rdq & rdq_full & ~flush;

    always_comb begin
        wb_evt = WB_IDLE;
        if (flush) begin
            wb_evt = WB_FLUSH;
        end else if (e2w_valid && w2e_stall) begin
            wb_evt = WB_STALL;
        end else if (e2w_valid) begin
            wb_evt = WB_ACCEPT;
        end
    end

    assign accept = (wb_evt == WB_ACCEPT);

    // Same-bundle WAW: a lane loses if any higher lane writes the same destination.
    for (genvar i = 0; i < NLANES; i++) begin : g_waw
        logic kill_lane;
        always_comb begin
            kill_lane = 1'b0;
            for (int j = i + 1; j < NLANES; j++) begin
                if (e2w_wr[j] &&
                    (e2w_dest[lane_lo(j, REG_AW) +: REG_AW] ==
                     e2w_dest[lane_lo(i, REG_AW) +: REG_AW])) begin
                    kill_lane = 1'b1;
                end
            end
        end
        assign kill[i] = kill_lane;
    end

    always_comb begin
        w2r_wr_d    = '0;
        w2re_dest_d = {NLANES{REG0_A}};
        w2re_data_d = '0;
        case (wb_evt)
            WB_ACCEPT: begin
                w2r_wr_d    = e2w_wr & ~kill;
                w2re_dest_d = e2w_dest;
                w2re_data_d = e2w_data;
            end
            default: begin
                w2r_wr_d    = '0;
                w2re_dest_d = {NLANES{REG0_A}};
                w2re_data_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            w2r_wr_q    <= '0;
            w2re_dest_q <= {NLANES{REG0_A}};
            w2re_data_q <= '0;
        end else begin
            w2r_wr_q    <= w2r_wr_d;
            w2re_dest_q <= w2re_dest_d;
            w2re_data_q <= w2re_data_d;
        end
    end

    assign w2r_wr    = w2r_wr_q;
    assign w2re_dest = w2re_dest_q;
    assign w2re_data = w2re_data_q;

    // Read entry carries only flagged lanes; the rest are zeroed so consumers never see stale data.
    always_comb begin
        rdq_push_data = '0;
        for (int i = 0; i < NLANES; i++) begin
            if (e2w_read[i]) begin
                rdq_push_data[lane_lo(i, DATA_W) +: DATA_W] = e2w_data[lane_lo(i, DATA_W) +: DATA_W];
            end
        end
    end

    assign rdq_push_entry = {e2w_read, rdq_push_data};

    wb_read_fifo #(
        .WIDTH (RQ_W),
        .DEPTH (RDQ_DEPTH)
    ) u_rdq (
        .clock     (clock),
        .reset     (reset),
        .push      (accept & need_rdq),
        .push_data (rdq_push_entry),
        .pop       (rd_ready),
        .rd_valid  (rd_valid),
        .rd_data   (rdq_head),
        .count     (rdq_count),
        .full      (rdq_full)
    );

    assign rd_mask = rdq_head[RQ_W-1 -: NLANES];
    assign rd_data = rdq_head[DW_ALL-1:0];

endmodule
